// File: rtl/bus_pkg.sv
// Shared memory-bus definitions: arbiter state encoding, default bus widths
// and the owner-selection rule used by the arbiter.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH = 20;
  localparam int BUS_DATA_WIDTH = 16;
  localparam int HOLD_WIDTH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } bus_state_e;

  // A tie goes to the master that did not own the bus last.
  function automatic bus_state_e pick_owner(logic r0, logic r1, logic last_owner);
    if (r0 && r1) return last_owner ? ST_OWN0 : ST_OWN1;
    if (r0)       return ST_OWN0;
    if (r1)       return ST_OWN1;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master memory bus arbiter with bounded hold time, a one-cycle turnaround
// and a shared tri-state data bus.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int MAX_HOLD   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic                  m1_read,
  input  logic                  m1_write,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  inout  logic [DATA_WIDTH-1:0] bus_data,
  output logic                  read,
  output logic                  write
);

  localparam logic [HOLD_WIDTH-1:0] HOLD_SAT  = HOLD_WIDTH'(MAX_HOLD);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);

  bus_state_e             state, state_nxt;
  logic                   last_owner, last_owner_nxt;
  logic [HOLD_WIDTH-1:0]  hold_cnt, hold_nxt;
  logic                   armed;
  logic                   m0_act, m1_act;
  logic                   m0_drv, m1_drv;

  // The first edge after reset release only arms the arbiter, so no grant
  // can appear before the second edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      armed      <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      hold_cnt   <= hold_nxt;
    end
  end

  // hold_cnt counts completed owned cycles, so HOLD_LAST marks the
  // MAX_HOLD-th owned cycle.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    hold_nxt       = hold_cnt;
    case (state)
      ST_IDLE, ST_TURN: begin
        state_nxt = pick_owner(m0_req, m1_req, last_owner);
        hold_nxt  = '0;
      end
      ST_OWN0: begin
        if (m0_req && (!m1_req || hold_cnt < HOLD_LAST)) begin
          if (hold_cnt != HOLD_SAT) hold_nxt = hold_cnt + 1'b1;
        end else begin
          state_nxt      = ST_TURN;
          last_owner_nxt = 1'b0;
        end
      end
      ST_OWN1: begin
        if (m1_req && (!m0_req || hold_cnt < HOLD_LAST)) begin
          if (hold_cnt != HOLD_SAT) hold_nxt = hold_cnt + 1'b1;
        end else begin
          state_nxt      = ST_TURN;
          last_owner_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign m0_gnt = (state == ST_OWN0);
  assign m1_gnt = (state == ST_OWN1);

  assign m0_act = m0_gnt && m0_req;
  assign m1_act = m1_gnt && m1_req;

  always_comb begin
    bus_addr = '0;
    write    = 1'b0;
    read     = 1'b0;
    if (m0_act) begin
      bus_addr = m0_addr;
      write    = m0_write;
      read     = m0_read && !m0_write;
    end else if (m1_act) begin
      bus_addr = m1_addr;
      write    = m1_write;
      read     = m1_read && !m1_write;
    end
  end

  assign m0_drv   = m0_gnt && m0_write;
  assign m1_drv   = m1_gnt && m1_write;
  assign bus_data = m0_drv ? m0_wdata : (m1_drv ? m1_wdata : 'z);
  assign rdata    = bus_data;

endmodule
